// File: rtl/rs232_cmd_pkg.sv
// Shared command codes, reply codes and FSM state type for the RS232 command responder.
package rs232_cmd_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
   localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
   localparam logic [7:0] RSP_ACK   = 8'h4B;  // 'K'
   localparam logic [7:0] RSP_NAK   = 8'h3F;  // '?'

   typedef enum logic [2:0] {
      IDLE,
      GET_ADDR,
      GET_DATA,
      RD_REQ,
      RD_CAP,
      TX_START,
      TX_HOLD,
      TX_WAIT
   } cmd_state_e;

   // Full 8-bit address byte must fit in addr_w bits to be a valid register.
   function automatic logic addr_in_range(input logic [7:0] addr, input int unsigned addr_w);
      if (addr_w >= 8) begin
         return 1'b1;
      end
      return (({24'd0, addr} >> addr_w) == 32'd0);
   endfunction

endpackage

// File: rtl/rs232_frame_timeout.sv
// Inter-byte timeout counter: clears on every received byte, counts only while
// enabled, and pulses terminal_o on the last allowed idle cycle.
module rs232_frame_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic terminal_o
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Next count; a received byte beats the terminal count, and the counter rests at 0
   // whenever the frame is not being assembled.
   always_comb begin
      terminal_o = enable_i && !clear_i && (cnt_q == CntLast);
      cnt_d      = '0;
      if (enable_i && !clear_i && !terminal_o) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rs232_cmd_responder.sv
// Byte command responder: decodes 'W' addr data / 'R' addr frames from the RS232
// receiver, drives a register-bus master and returns one reply byte per command.
module rs232_cmd_responder
   import rs232_cmd_pkg::*;
#(
   parameter int unsigned ADDR_W         = 4,
   parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic [7:0]        iRxD_DATA,
   input  logic              iRxD_Ready,
   output logic [7:0]        oTxD_DATA,
   output logic              oTxD_Start,
   input  logic              iTxD_Busy,
   output logic [ADDR_W-1:0] oREG_ADDR,
   output logic [7:0]        oREG_WDATA,
   output logic              oREG_WR,
   output logic              oREG_RD,
   input  logic [7:0]        iREG_RDATA
);

   cmd_state_e        state_q, state_d;
   logic              is_wr_q, is_wr_d;
   logic              addr_ok_q, addr_ok_d;
   logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic              rd_q, rd_d;
   logic              rdcap_q, rdcap_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              start_q, start_d;
   logic              tmo_en;
   logic              tmo_hit;

   assign tmo_en = (state_q == GET_ADDR) || (state_q == GET_DATA);

   rs232_frame_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i     (iCLK),
      .rst_ni    (iRST_N),
      .clear_i   (iRxD_Ready),
      .enable_i  (tmo_en),
      .terminal_o(tmo_hit)
   );

   // Frame decode, bus strobes and reply handshake.
   always_comb begin
      state_d    = state_q;
      is_wr_d    = is_wr_q;
      addr_ok_d  = addr_ok_q;
      reg_addr_d = reg_addr_q;
      wdata_d    = wdata_q;
      tx_data_d  = tx_data_q;
      wr_d       = 1'b0;
      rd_d       = 1'b0;
      start_d    = 1'b0;
      // Read data is valid the cycle after the read strobe, i.e. first cycle of TX_START.
      rdcap_d    = rd_q;

      unique case (state_q)
         IDLE: begin
            if (iRxD_Ready) begin
               if ((iRxD_DATA == CMD_WRITE) || (iRxD_DATA == CMD_READ)) begin
                  is_wr_d = (iRxD_DATA == CMD_WRITE);
                  state_d = GET_ADDR;
               end else begin
                  tx_data_d = RSP_NAK;
                  state_d   = TX_START;
               end
            end
         end
         GET_ADDR: begin
            if (iRxD_Ready) begin
               reg_addr_d = ADDR_W'(iRxD_DATA);
               addr_ok_d  = addr_in_range(iRxD_DATA, ADDR_W);
               if (is_wr_q) begin
                  state_d = GET_DATA;
               end else if (addr_ok_d) begin
                  state_d = RD_REQ;
               end else begin
                  tx_data_d = RSP_NAK;
                  state_d   = TX_START;
               end
            end else if (tmo_hit) begin
               state_d = IDLE;
            end
         end
         GET_DATA: begin
            if (iRxD_Ready) begin
               if (addr_ok_q) begin
                  wr_d      = 1'b1;
                  wdata_d   = iRxD_DATA;
                  tx_data_d = RSP_ACK;
               end else begin
                  tx_data_d = RSP_NAK;
               end
               state_d = TX_START;
            end else if (tmo_hit) begin
               state_d = IDLE;
            end
         end
         RD_REQ: begin
            rd_d    = 1'b1;
            state_d = RD_CAP;
         end
         RD_CAP: begin
            state_d = TX_START;
         end
         TX_START: begin
            if (rdcap_q) begin
               tx_data_d = iREG_RDATA;
            end
            // Hold off while a previous byte is still leaving the transmitter.
            if (!iTxD_Busy) begin
               start_d = 1'b1;
               state_d = TX_HOLD;
            end
         end
         TX_HOLD: begin
            state_d = TX_WAIT;
         end
         TX_WAIT: begin
            if (!iTxD_Busy) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q    <= IDLE;
         is_wr_q    <= 1'b0;
         addr_ok_q  <= 1'b0;
         reg_addr_q <= '0;
         wdata_q    <= '0;
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
         rdcap_q    <= 1'b0;
         tx_data_q  <= '0;
         start_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_wr_q    <= is_wr_d;
         addr_ok_q  <= addr_ok_d;
         reg_addr_q <= reg_addr_d;
         wdata_q    <= wdata_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         rdcap_q    <= rdcap_d;
         tx_data_q  <= tx_data_d;
         start_q    <= start_d;
      end
   end

   assign oTxD_DATA  = tx_data_q;
   assign oTxD_Start = start_q;
   assign oREG_ADDR  = reg_addr_q;
   assign oREG_WDATA = wdata_q;
   assign oREG_WR    = wr_q;
   assign oREG_RD    = rd_q;

endmodule

// File: tb/tb_rs232_cmd_responder.sv
// Randomized bench for rs232_cmd_responder with a frame-level reference model.
module tb_rs232_cmd_responder;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned TMO    = 100;
   localparam logic [7:0]  OP_W   = 8'h57;
   localparam logic [7:0]  OP_R   = 8'h52;
   localparam logic [7:0]  ACK    = 8'h4B;
   localparam logic [7:0]  NAK    = 8'h3F;

   logic              iCLK = 1'b0;
   logic              iRST_N = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_ready = 1'b0;
   logic [7:0]        oTxD_DATA;
   logic              oTxD_Start;
   logic              tx_busy = 1'b0;
   logic              busy_force = 1'b0;
   logic              busy_in;
   logic [ADDR_W-1:0] oREG_ADDR;
   logic [7:0]        oREG_WDATA;
   logic              oREG_WR;
   logic              oREG_RD;
   logic [7:0]        rdata = 8'h00;

   assign busy_in = tx_busy | busy_force;

   rs232_cmd_responder #(
      .ADDR_W        (ADDR_W),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .iCLK      (iCLK),
      .iRST_N    (iRST_N),
      .iRxD_DATA (rx_data),
      .iRxD_Ready(rx_ready),
      .oTxD_DATA (oTxD_DATA),
      .oTxD_Start(oTxD_Start),
      .iTxD_Busy (busy_in),
      .oREG_ADDR (oREG_ADDR),
      .oREG_WDATA(oREG_WDATA),
      .oREG_WR   (oREG_WR),
      .oREG_RD   (oREG_RD),
      .iREG_RDATA(rdata)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      int kind;  // 1 = write, 2 = read
      int addr;
      int data;
      int cyc;
   } bus_ev_t;

   typedef struct {
      int data;
      int cyc;  // -1: timing not checked
   } tx_ev_t;

   bus_ev_t    exp_bus[$];
   bus_ev_t    act_bus[$];
   tx_ev_t     exp_tx[$];
   tx_ev_t     act_tx[$];
   logic [7:0] model_mem[16];
   logic [7:0] dev_mem[16];
   int         n_chk = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         tx_left = 0;
   int         rd_stage = 0;
   int         rd_addr_pend = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Monitor, transmitter model and register-file responder, one tick per cycle.
   always @(posedge iCLK) begin
      #1;
      cyc++;
      if (tx_left > 0) begin
         tx_busy = 1'b1;
         tx_left--;
      end else begin
         tx_busy = 1'b0;
      end
      if (oTxD_Start) begin
         act_tx.push_back('{int'(oTxD_DATA), cyc});
         tx_left = $urandom_range(2, 6);
      end
      if (oREG_WR) begin
         act_bus.push_back('{1, int'(oREG_ADDR), int'(oREG_WDATA), cyc});
         dev_mem[oREG_ADDR] = oREG_WDATA;
      end
      // Read data valid only in the cycle after the strobe; garbage otherwise.
      if (rd_stage == 1) begin
         rdata    = dev_mem[rd_addr_pend];
         rd_stage = 0;
      end else begin
         rdata = 8'($urandom);
      end
      if (oREG_RD) begin
         act_bus.push_back('{2, int'(oREG_ADDR), 0, cyc});
         rd_addr_pend = int'(oREG_ADDR);
         rd_stage     = 1;
      end
      check("strobe_excl", int'(oREG_WR & oREG_RD), 0);
   end

   // Called at a negedge; leaves the bench at a negedge after idle quiet cycles.
   task automatic send_byte(input logic [7:0] b, input int idle, output int rc);
      rx_data  = b;
      rx_ready = 1'b1;
      rc       = cyc;
      @(negedge iCLK);
      rx_ready = 1'b0;
      repeat (idle) @(negedge iCLK);
   endtask

   // Sends one frame and records what the command rules say must happen.
   task automatic run_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                            input int g1, input int g2, input bit chk_cyc);
      int rc;
      send_byte(op, g1, rc);
      if (op != OP_W && op != OP_R) begin
         exp_tx.push_back('{int'(NAK), chk_cyc ? rc + 2 : -1});
         return;
      end
      send_byte(a, (op == OP_W) ? g2 : 0, rc);
      if (op == OP_R) begin
         if (a < 16) begin
            exp_bus.push_back('{2, int'(a), 0, rc + 2});
            exp_tx.push_back('{int'(model_mem[a[3:0]]), chk_cyc ? rc + 4 : -1});
         end else begin
            exp_tx.push_back('{int'(NAK), chk_cyc ? rc + 2 : -1});
         end
         return;
      end
      send_byte(d, 0, rc);
      if (a < 16) begin
         exp_bus.push_back('{1, int'(a), int'(d), rc + 1});
         model_mem[a[3:0]] = d;
         exp_tx.push_back('{int'(ACK), chk_cyc ? rc + 2 : -1});
      end else begin
         exp_tx.push_back('{int'(NAK), chk_cyc ? rc + 2 : -1});
      end
   endtask

   task automatic compare_all();
      bus_ev_t e;
      bus_ev_t g;
      tx_ev_t  te;
      tx_ev_t  tg;
      while (exp_bus.size() > 0) begin
         e = exp_bus.pop_front();
         if (act_bus.size() == 0) begin
            check("bus_missing", 0, e.kind);
         end else begin
            g = act_bus.pop_front();
            check("bus_kind", g.kind, e.kind);
            check("bus_addr", g.addr, e.addr);
            check("bus_wdata", g.data, e.data);
            check("bus_cycle", g.cyc, e.cyc);
         end
      end
      check("bus_extra", act_bus.size(), 0);
      act_bus.delete();
      while (exp_tx.size() > 0) begin
         te = exp_tx.pop_front();
         if (act_tx.size() == 0) begin
            check("reply_missing", 0, te.data);
         end else begin
            tg = act_tx.pop_front();
            check("reply_data", tg.data, te.data);
            if (te.cyc >= 0) check("reply_cycle", tg.cyc, te.cyc);
         end
      end
      check("reply_extra", act_tx.size(), 0);
      act_tx.delete();
   endtask

   // Waits (bounded) for all expected replies and the transmitter to drain.
   task automatic finish_frame();
      int i;
      i = 0;
      while (act_tx.size() < exp_tx.size() && i < 400) begin
         @(negedge iCLK);
         i++;
      end
      if (act_tx.size() < exp_tx.size()) check("reply_wait", act_tx.size(), exp_tx.size());
      i = 0;
      while ((tx_left > 0 || tx_busy) && i < 50) begin
         @(negedge iCLK);
         i++;
      end
      repeat (3) @(negedge iCLK);
      compare_all();
   endtask

   task automatic check_zero(input string where);
      check({where, "_txdata"}, int'(oTxD_DATA), 0);
      check({where, "_start"}, int'(oTxD_Start), 0);
      check({where, "_addr"}, int'(oREG_ADDR), 0);
      check({where, "_wdata"}, int'(oREG_WDATA), 0);
      check({where, "_wr"}, int'(oREG_WR), 0);
      check({where, "_rd"}, int'(oREG_RD), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish by 500000");
      $fatal(1, "watchdog");
   end

   initial begin
      int         rc;
      int         i;
      int         r;
      logic [7:0] op;
      logic [7:0] a;
      for (int k = 0; k < 16; k++) begin
         model_mem[k] = 8'($urandom);
         dev_mem[k]   = model_mem[k];
      end
      repeat (3) @(negedge iCLK);
      check_zero("reset");
      iRST_N = 1'b1;
      repeat (2) @(negedge iCLK);

      // Directed write, read, bad opcode, out-of-range read and write.
      run_frame(OP_W, 8'h03, 8'hA5, 0, 0, 1'b1);
      finish_frame();
      model_mem[7] = 8'h3C;
      dev_mem[7]   = 8'h3C;
      run_frame(OP_R, 8'h07, 8'h00, 0, 0, 1'b1);
      finish_frame();
      run_frame(8'h41, 8'h00, 8'h00, 0, 0, 1'b1);
      finish_frame();
      run_frame(OP_R, 8'h10, 8'h00, 0, 0, 1'b1);
      finish_frame();
      run_frame(OP_W, 8'h20, 8'h77, 2, 1, 1'b1);
      finish_frame();

      // Timeout drops the frame; one cycle less of silence keeps it alive.
      send_byte(OP_W, 0, rc);
      send_byte(8'h02, TMO, rc);
      run_frame(OP_R, 8'h02, 8'h00, 0, 0, 1'b1);
      finish_frame();
      run_frame(OP_W, 8'h02, 8'h5A, 0, TMO - 1, 1'b1);
      finish_frame();
      run_frame(OP_R, 8'h02, 8'h00, TMO - 1, 0, 1'b1);
      finish_frame();

      // Transmitter still busy when the reply is ready.
      busy_force = 1'b1;
      run_frame(8'h41, 8'h00, 8'h00, 0, 0, 1'b0);
      repeat (20) @(negedge iCLK);
      check("busy_hold_start", act_tx.size(), 0);
      busy_force = 1'b0;
      finish_frame();

      // Bytes arriving while the reply is going out are ignored.
      run_frame(OP_W, 8'h05, 8'h11, 0, 0, 1'b1);
      i = 0;
      while (act_tx.size() == 0 && i < 50) begin
         @(negedge iCLK);
         i++;
      end
      send_byte(OP_W, 0, rc);
      send_byte(OP_R, 0, rc);
      finish_frame();
      run_frame(OP_R, 8'h05, 8'h00, 0, 0, 1'b1);
      finish_frame();

      // Reset in the middle of a frame.
      send_byte(OP_W, 0, rc);
      send_byte(8'h05, 0, rc);
      iRST_N = 1'b0;
      #1;
      check_zero("rst_getdata");
      @(negedge iCLK);
      iRST_N = 1'b1;
      repeat (2) @(negedge iCLK);

      // Reset while the reply is being transmitted.
      run_frame(OP_W, 8'h09, 8'h66, 0, 0, 1'b1);
      i = 0;
      while (act_tx.size() == 0 && i < 50) begin
         @(negedge iCLK);
         i++;
      end
      @(negedge iCLK);
      iRST_N = 1'b0;
      #1;
      check_zero("rst_txwait");
      @(negedge iCLK);
      iRST_N = 1'b1;
      finish_frame();
      run_frame(OP_R, 8'h09, 8'h00, 0, 0, 1'b1);
      finish_frame();

      // Random frames.
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         if (r < 4) begin
            op = OP_W;
         end else if (r < 8) begin
            op = OP_R;
         end else begin
            op = 8'($urandom);
            while (op == OP_W || op == OP_R) op = 8'($urandom);
         end
         a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255))
                                         : 8'($urandom_range(0, 15));
         run_frame(op, a, 8'($urandom), $urandom_range(0, 4), $urandom_range(0, 4), 1'b1);
         finish_frame();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
